// File: rtl/kb_event_pkg.sv
// Shared event-code fields, scanner state type and code builders for the panel event scanner.
package kb_event_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_ENC     = 2'b11;

  typedef enum logic {S_IDLE, S_SCAN} scan_state_e;

  function automatic logic [7:0] enc_code(input logic [4:0] ch, input logic ccw);
    return {EVT_ENC, ch, ccw};
  endfunction

  function automatic logic [7:0] key_code(input logic pressed, input logic [5:0] idx);
    return {(pressed ? EVT_PRESS : EVT_RELEASE), idx};
  endfunction

endpackage

// File: rtl/sync_event_fifo.sv
// First-word fall-through event FIFO; a push while full is accepted only alongside a pop.
module sync_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kb_event_scanner.sv
// Debounces panel keys and quadrature encoders and queues press/release/rotate codes.
// Scanner states: S_IDLE | committed == reported ; S_SCAN | walking keys, one index per clk
module kb_event_scanner import kb_event_pkg::*; #(
  parameter int NUM_KEYS       = 32,
  parameter int NUM_ENC        = 4,
  parameter int SCAN_DIV       = 48000,
  parameter int KEY_DEBOUNCE   = 8,
  parameter int ENC_DEBOUNCE   = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_in,
  input  logic [NUM_ENC-1:0]  enc_a,
  input  logic [NUM_ENC-1:0]  enc_b,
  output logic                evt_valid,
  output logic [7:0]          evt_code,
  input  logic                evt_ready,
  output logic                evt_overflow,
  input  logic                ovf_clr
);
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int EW = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]       PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [KW-1:0]       IDX_LAST = KW'(NUM_KEYS - 1);
  localparam logic [7:0]          KEY_LAST = 8'(KEY_DEBOUNCE - 1);
  localparam logic [7:0]          KEY_SAT  = 8'(KEY_DEBOUNCE);
  localparam logic [7:0]          ENC_LAST = 8'(ENC_DEBOUNCE - 1);
  localparam logic [7:0]          ENC_SAT  = 8'(ENC_DEBOUNCE);
  localparam logic [NUM_KEYS-1:0] KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  logic [NUM_KEYS-1:0] k_s1_q, k_s2_q, k_smp, k_prev_q, k_com_q, rep_q;
  logic [NUM_ENC-1:0]  a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [PW-1:0]       pre_q;
  logic                tick;
  logic [7:0]          k_cnt_q;
  scan_state_e         state_q;
  logic [KW-1:0]       idx_q;
  logic                key_diff, key_req, key_gnt;
  logic [7:0]          key_evt;

  logic [NUM_ENC-1:0][1:0] e_smp, e_prev_q, e_dec_q;
  logic [NUM_ENC-1:0][7:0] e_cnt_q;
  logic                    e_init_q;
  logic [NUM_ENC-1:0]      e_det, e_ccw, pend_q, dir_q, e_gnt;
  logic [EW-1:0]           e_sel;
  logic                    enc_any, can_push, pop, push, fifo_full, fifo_empty;
  logic [7:0]              push_data, fifo_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_s1_q <= KEY_IDLE;
      k_s2_q <= KEY_IDLE;
      a_s1_q <= '0;
      a_s2_q <= '0;
      b_s1_q <= '0;
      b_s2_q <= '0;
      pre_q  <= '0;
    end else begin
      k_s1_q <= keys_in;
      k_s2_q <= k_s1_q;
      a_s1_q <= enc_a;
      a_s2_q <= a_s1_q;
      b_s1_q <= enc_b;
      b_s2_q <= b_s1_q;
      pre_q  <= tick ? '0 : pre_q + PW'(1);
    end
  end

  assign tick  = (pre_q == PRE_LAST);
  assign k_smp = (KEY_ACTIVE_LOW != 0) ? ~k_s2_q : k_s2_q;

  // Counter saturates at KEY_DEBOUNCE so a held key commits exactly once per change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_prev_q <= '0;
      k_cnt_q  <= KEY_SAT;
      k_com_q  <= '0;
    end else if (tick) begin
      if (k_smp != k_prev_q) begin
        k_prev_q <= k_smp;
        k_cnt_q  <= '0;
      end else if (k_cnt_q != KEY_SAT) begin
        k_cnt_q <= k_cnt_q + 8'd1;
        if (k_cnt_q == KEY_LAST) k_com_q <= k_smp;
      end
    end
  end

  assign key_diff = k_com_q[idx_q] ^ rep_q[idx_q];
  assign key_req  = (state_q == S_SCAN) && key_diff;
  assign key_evt  = key_code(k_com_q[idx_q], 6'(idx_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rep_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (k_com_q != rep_q) begin
          state_q <= S_SCAN;
          idx_q   <= '0;
        end
        S_SCAN: if (!key_diff || key_gnt) begin
          if (key_gnt) rep_q[idx_q] <= k_com_q[idx_q];
          if (idx_q == IDX_LAST) state_q <= S_IDLE;
          else                   idx_q   <= idx_q + KW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Detent: decoded pair leaves A!=B for A==B; B unchanged across it means CCW.
  always_comb begin
    e_smp = '0;
    e_det = '0;
    e_ccw = '0;
    for (int ch = 0; ch < NUM_ENC; ch++) begin
      e_smp[ch] = {a_s2_q[ch], b_s2_q[ch]};
      e_ccw[ch] = (e_smp[ch][0] == e_dec_q[ch][0]);
      e_det[ch] = tick && e_init_q && (e_smp[ch] == e_prev_q[ch]) && (e_cnt_q[ch] == ENC_LAST)
                  && (e_dec_q[ch][1] != e_dec_q[ch][0]) && (e_smp[ch][1] == e_smp[ch][0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_prev_q <= '0;
      e_dec_q  <= '0;
      e_cnt_q  <= '0;
      e_init_q <= 1'b0;
    end else if (tick) begin
      e_init_q <= 1'b1;
      for (int ch = 0; ch < NUM_ENC; ch++) begin
        if (!e_init_q) begin
          e_prev_q[ch] <= e_smp[ch];
          e_dec_q[ch]  <= e_smp[ch];
          e_cnt_q[ch]  <= ENC_SAT;
        end else if (e_smp[ch] != e_prev_q[ch]) begin
          e_prev_q[ch] <= e_smp[ch];
          e_cnt_q[ch]  <= '0;
        end else if (e_cnt_q[ch] != ENC_SAT) begin
          e_cnt_q[ch] <= e_cnt_q[ch] + 8'd1;
          if (e_cnt_q[ch] == ENC_LAST) e_dec_q[ch] <= e_smp[ch];
        end
      end
    end
  end

  always_comb begin
    e_sel = '0;
    for (int i = NUM_ENC - 1; i >= 0; i--) begin
      if (pend_q[i]) e_sel = EW'(i);
    end
    enc_any  = |pend_q;
    pop      = !fifo_empty && evt_ready;
    can_push = !fifo_full || pop;
    e_gnt    = '0;
    if (enc_any && can_push) e_gnt[e_sel] = 1'b1;
    key_gnt   = !enc_any && key_req && can_push;
    push      = (enc_any || key_req) && can_push;
    push_data = enc_any ? enc_code(5'(e_sel), dir_q[e_sel]) : key_evt;
  end

  // A detent landing in the same cycle its predecessor is granted is not a loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      dir_q        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_ENC; ch++) begin
        if (e_det[ch]) begin
          pend_q[ch] <= 1'b1;
          dir_q[ch]  <= e_ccw[ch];
        end else if (e_gnt[ch]) begin
          pend_q[ch] <= 1'b0;
        end
      end
      if (|(e_det & pend_q & ~e_gnt)) evt_overflow <= 1'b1;
      else if (ovf_clr)               evt_overflow <= 1'b0;
    end
  end

  sync_event_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .data_o  (fifo_data)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_valid ? fifo_data : 8'h00;

endmodule

// File: tb/tb_kb_event_scanner.sv
// Directed bench for kb_event_scanner: keys, encoders, FIFO back-pressure, overflow and reset.
module tb_kb_event_scanner;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] keys_in;
  logic [3:0]  enc_a, enc_b;
  logic        evt_valid, evt_ready, evt_overflow, ovf_clr;
  logic [7:0]  evt_code;
  int          passed = 0;
  int          total  = 0;

  kb_event_scanner #(
    .NUM_KEYS(32), .NUM_ENC(4), .SCAN_DIV(4), .KEY_DEBOUNCE(4),
    .ENC_DEBOUNCE(2), .FIFO_DEPTH(4), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .enc_a(enc_a), .enc_b(enc_b),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic get_evt(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (evt_valid) break;
    end
    check({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
    check({tag, "_code"}, {24'd0, evt_code}, {24'd0, exp});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (evt_valid) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; keys_in = '1; enc_a = '0; enc_b = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    clks(3);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_code", {24'd0, evt_code}, 32'd0);
    check("rst_ovf", {31'd0, evt_overflow}, 32'd0);
    rst = 1'b0;
    quiet("idle_200", 200);

    // key 5 bounces for three ticks, then settles pressed
    keys_in[5] = 1'b0; clks(4);
    keys_in[5] = 1'b1; clks(4);
    keys_in[5] = 1'b0; clks(4);
    keys_in[5] = 1'b1; clks(4);
    keys_in[5] = 1'b0;
    get_evt("k5_press", 8'h45);
    quiet("k5_single", 80);
    keys_in[5] = 1'b1;
    get_evt("k5_release", 8'h85);
    quiet("k5_rel_single", 80);

    keys_in[3] = 1'b0; keys_in[17] = 1'b0;
    get_evt("k3_press", 8'h43);
    get_evt("k17_press", 8'h51);
    keys_in[3] = 1'b1; keys_in[17] = 1'b1;
    get_evt("k3_release", 8'h83);
    get_evt("k17_release", 8'h91);
    quiet("k3_17_done", 60);

    // encoder 2: 00 -> 10 -> 11 is CW, 11 -> 10 -> 00 is CCW
    enc_a[2] = 1'b1; clks(16);
    enc_b[2] = 1'b1;
    get_evt("enc2_cw", 8'hC4);
    clks(16);
    enc_b[2] = 1'b0; clks(16);
    enc_a[2] = 1'b0;
    get_evt("enc2_ccw", 8'hC5);
    quiet("enc2_done", 40);
    check("enc2_ovf", {31'd0, evt_overflow}, 32'd0);

    // six presses into a 4-deep FIFO with the consumer stalled
    keys_in[0] = 1'b0; keys_in[1] = 1'b0; keys_in[2] = 1'b0;
    keys_in[4] = 1'b0; keys_in[6] = 1'b0; keys_in[8] = 1'b0;
    clks(150);
    check("stall_head", {24'd0, evt_code}, 32'h40);
    get_evt("bp_0", 8'h40);
    get_evt("bp_1", 8'h41);
    get_evt("bp_2", 8'h42);
    get_evt("bp_4", 8'h44);
    get_evt("bp_6", 8'h46);
    get_evt("bp_8", 8'h48);
    quiet("bp_done", 40);
    check("bp_ovf", {31'd0, evt_overflow}, 32'd0);
    keys_in = '1;
    get_evt("bp_rel0", 8'h80);
    get_evt("bp_rel1", 8'h81);
    get_evt("bp_rel2", 8'h82);
    get_evt("bp_rel4", 8'h84);
    get_evt("bp_rel6", 8'h86);
    get_evt("bp_rel8", 8'h88);
    quiet("bp_rel_done", 40);

    // fill FIFO with keys 10..13, then two encoder-0 detents while full
    keys_in[13:10] = 4'b0000;
    clks(100);
    enc_a[0] = 1'b1; clks(16);
    enc_b[0] = 1'b1; clks(16);
    enc_a[0] = 1'b0; clks(16);
    enc_b[0] = 1'b0; clks(16);
    check("ovf_set", {31'd0, evt_overflow}, 32'd1);
    get_evt("ovf_k10", 8'h4A);
    get_evt("ovf_k11", 8'h4B);
    get_evt("ovf_k12", 8'h4C);
    get_evt("ovf_k13", 8'h4D);
    get_evt("ovf_enc0", 8'hC0);
    quiet("ovf_one_enc", 60);
    check("ovf_sticky", {31'd0, evt_overflow}, 32'd1);
    ovf_clr = 1'b1; clks(1);
    ovf_clr = 1'b0; clks(1);
    check("ovf_cleared", {31'd0, evt_overflow}, 32'd0);

    keys_in = '1;
    clks(100);
    check("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
    check("mid_rst_code", {24'd0, evt_code}, 32'd0);
    clks(2);
    rst = 1'b0;
    quiet("post_rst_quiet", 150);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2000000");
    $fatal(1);
  end

endmodule

// File: doc/kb_event_scanner.md
Name: kb_event_scanner

Overview:
Parametrised successor of the panel keyboard reader. Samples NUM_KEYS push-buttons and NUM_ENC quadrature encoders in a single clk domain, debounces them and emits 8-bit press/release/rotate event codes. Events go through an event FIFO with a valid/ready handshake, so no event is dropped when the host interface is slow. Sits between the panel pins and the host-link serialiser.

Parameters:
NUM_KEYS, 32, number of key inputs (1..64)
NUM_ENC, 4, number of quadrature encoders (1..32)
SCAN_DIV, 48000, clk cycles per scan tick (>=2)
KEY_DEBOUNCE, 8, scan ticks the key vector must be stable before commit (1..255)
ENC_DEBOUNCE, 4, scan ticks an encoder line pair must be stable before decode (1..255)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
KEY_ACTIVE_LOW, 1, 1 = pressed key reads 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
keys_in  in  NUM_KEYS  raw key lines
enc_a  in  NUM_ENC  raw encoder A lines
enc_b  in  NUM_ENC  raw encoder B lines
evt_valid  out  1  FIFO head holds an event
evt_code  out  8  event code at FIFO head
evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
evt_overflow  out  1  sticky: an encoder detent was lost
ovf_clr  in  1  clears evt_overflow (1-cycle pulse)

Behaviour:
- Reset: evt_valid=0, evt_code=0, evt_overflow=0; FIFO empty; prescaler=0; debounced and reported key state = all released; encoder state loaded from synchronised lines on the first tick after reset with no event.
- All raw inputs pass 2-flop synchronisers. Prescaler counts 0..SCAN_DIV-1 and pulses tick for one clk on wrap.
- Event code: [7:6]=01 press, 10 release, 11 encoder; [5:0] key index, or 2*enc+dir for encoders (dir 0 = CW, 1 = CCW).
- Key debounce (per tick): sample the vector; if it differs from the previous sample, restart the stability counter; when it reaches KEY_DEBOUNCE, copy the sample to committed state. The counter saturates and does not re-commit until the next change.
- Key scanner FSM: IDLE -> SCAN when committed != reported. SCAN walks index 0..NUM_KEYS-1, one bit per clk. On a differing bit it requests a push. When the push is granted it updates reported[idx] and advances. If the FIFO is full or the arbiter does not grant, it holds idx; it never skips. After the last index -> IDLE. A commit arriving mid-scan is picked up by a rescan from IDLE, so no diff is lost.
- Encoder path, per channel: A/B stable ENC_DEBOUNCE ticks -> decoded state. A detent is a transition from A!=B to A==B. Direction: CW if the new B differs from the previous B, else CCW. A detent sets pend[ch] and dir[ch].
- A detent on a channel whose pend is still set overwrites dir and sets evt_overflow.
- Arbiter, one push per clk: pending encoders first, lowest channel first; otherwise the key scanner. A push is granted only when the FIFO is not full or a pop happens in the same cycle.
- FIFO: first-word fall-through. evt_code shows the head while evt_valid=1. Push and pop in the same cycle are allowed when full or empty-with-push. Latency from push to evt_valid is 1 clk.
- evt_overflow: set has priority over ovf_clr in the same cycle.
- rst mid-operation clears everything immediately. Pending and in-flight events are discarded.

Decomposition:
- Package kb_event_pkg: code-field constants EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_ENC=2'b11; function for encoder code build; scanner FSM state enum (S_IDLE, S_SCAN).
- Sub-module sync_event_fifo (WIDTH=8, DEPTH=FIFO_DEPTH) with push/full/pop/empty. Instantiated once.

Test Plan:
- Reset then idle with all keys high (KEY_ACTIVE_LOW=1), SCAN_DIV=4: evt_valid stays 0 for 200 clk.
- Key 5 low with bounce for 3 ticks, then stable: exactly one code 0x45 after KEY_DEBOUNCE stable ticks. Release -> one 0x85.
- Keys 3 and 17 pressed in the same tick: 0x43 then 0x51, in index order.
- Encoder 2 one CW detent, then one CCW: codes 0xC4 then 0xC5.
- evt_ready=0, FIFO_DEPTH=4, 6 keys pressed: 4 events queued, scanner stalls. Raise evt_ready: all 6 delivered in order, evt_overflow=0.
- evt_ready=0, FIFO full, two detents on encoder 0: evt_overflow=1, one encoder event delivered later. Pulse ovf_clr -> evt_overflow=0. Assert rst mid-stream -> evt_valid=0 next cycle.
